// File: rtl/image_stream_loader.sv
// Frame loader: streams IMG_WIDTH*IMG_HEIGHT pixels from a 1-cycle-latency memory
// through a credit-controlled FIFO. Define LOADER_LAST_EN to add the out_last port.
module image_stream_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef LOADER_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int NW    = $clog2(FIFO_DEPTH + 1);
`ifdef LOADER_LAST_EN
  localparam int EW    = DATA_WIDTH + 1;
`else
  localparam int EW    = DATA_WIDTH;
`endif
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_C  = CW'(TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_issued, r_sent;
  logic                  r_inflight;
  logic [EW-1:0]         r_fifo [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [NW-1:0]         r_count;
  logic                  w_push, w_pop, w_credit;
  logic [EW-1:0]         w_wdata, w_head;

`ifdef LOADER_LAST_EN
  logic r_inflight_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight_last <= 1'b0;
    else        r_inflight_last <= mem_rd_en && (r_issued == LAST_C);
  end

  assign w_wdata  = {r_inflight_last, mem_rd_data};
  assign out_last = out_valid & w_head[EW-1];
`else
  assign w_wdata  = mem_rd_data;
`endif

  // Reset clears r_inflight, so a read issued just before reset is never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= mem_rd_en;
      if (r_state == S_IDLE && start) begin
        r_base   <= base_addr;
        r_issued <= '0;
        r_sent   <= '0;
      end else begin
        if (mem_rd_en) r_issued <= r_issued + CW'(1);
        if (w_pop)     r_sent   <= r_sent + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_wdata;
  end

  // Credit counts the in-flight read so the FIFO can never overflow on capture.
  assign w_credit    = ({1'b0, r_count} + {{NW{1'b0}}, r_inflight}) < (NW+1)'(FIFO_DEPTH);
  assign mem_rd_en   = (r_state == S_FETCH) && (r_issued < TOTAL_C) && w_credit;
  assign mem_rd_addr = r_base + ADDR_WIDTH'(r_issued);
  assign w_push      = r_inflight;
  assign out_valid   = (r_count != '0);
  assign w_pop       = out_valid && out_ready;
  assign w_head      = r_fifo[r_rptr];
  assign out_data    = out_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign busy        = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (mem_rd_en && r_issued == LAST_C) w_next = S_DRAIN;
      S_DRAIN: if (r_count == '0 && !r_inflight && r_sent == TOTAL_C) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_image_stream_loader.sv
// Scoreboard bench for image_stream_loader (4x2 frame, 4-entry FIFO, memory[a]=a).
module tb_image_stream_loader;
  localparam int DW = 16, AW = 16, IW = 4, IH = 2, DEPTH = 4, TOTAL = IW * IH;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, mem_rd_en, out_valid;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] out_data;
`ifdef LOADER_LAST_EN
  logic          out_last;
  bit            exp_last[$];
  logic          prev_last = 1'b0;
`endif

  image_stream_loader #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef LOADER_LAST_EN
    , .out_last(out_last)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memory whose content equals its address.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_rd_addr;

  int            errors = 0, checks = 0;
  int            n_xfer = 0, n_rd = 0, n_done = 0;
  logic [DW-1:0] exp_pix[$];
  logic [AW-1:0] exp_addr[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Sample at a falling edge, score what commits at the next rising edge, advance.
  task automatic tick();
    logic [DW-1:0] e;
    logic [AW-1:0] a;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_pix.size() == 0) begin
        errors++; $display("FAIL pixel_extra: got %h, required no transfer", out_data);
      end else begin
        e = exp_pix.pop_front();
        if (out_data !== e) begin errors++; $display("FAIL pixel: got %h, required %h", out_data, e); end
      end
`ifdef LOADER_LAST_EN
      checks++;
      if (exp_last.size() == 0 || out_last !== exp_last.pop_front()) begin
        errors++; $display("FAIL last: got %b at pixel %h", out_last, out_data);
      end
`endif
      n_xfer++;
    end
    if (mem_rd_en) begin
      checks++;
      if (exp_addr.size() == 0) begin
        errors++; $display("FAIL addr_extra: got %h, required no read", mem_rd_addr);
      end else begin
        a = exp_addr.pop_front();
        if (mem_rd_addr !== a) begin errors++; $display("FAIL addr: got %h, required %h", mem_rd_addr, a); end
      end
      n_rd++;
    end
    if (prev_stall) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data) begin
        errors++; $display("FAIL stall_hold: got v=%b d=%h, required v=1 d=%h", out_valid, out_data, prev_data);
      end
`ifdef LOADER_LAST_EN
      checks++;
      if (out_last !== prev_last) begin errors++; $display("FAIL stall_last: got %b, required %b", out_last, prev_last); end
`endif
    end
    if (done) n_done++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
`ifdef LOADER_LAST_EN
    prev_last  = out_last;
`endif
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [AW-1:0] b);
    n_xfer = 0; n_rd = 0; n_done = 0;
    for (int i = 0; i < TOTAL; i++) begin
      exp_addr.push_back(b + AW'(i));
      exp_pix.push_back(b + AW'(i));
`ifdef LOADER_LAST_EN
      exp_last.push_back(i == TOTAL - 1);
`endif
    end
    base_addr = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks += 6;
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    if (mem_rd_en !== 1'b0)  begin errors++; $display("FAIL rst_rd_en: got %b, required 0", mem_rd_en); end
    if (mem_rd_addr !== '0)  begin errors++; $display("FAIL rst_rd_addr: got %h, required 0", mem_rd_addr); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    if (out_data !== '0)     begin errors++; $display("FAIL rst_data: got %h, required 0", out_data); end
`ifdef LOADER_LAST_EN
    checks++;
    if (out_last !== 1'b0)   begin errors++; $display("FAIL rst_last: got %b, required 0", out_last); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int k = 0, fv = -1, frd = -1, lrd = -1, fx = -1, lx = -1;
    out_ready = 1'b1;
    start_frame(16'h0010);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy: got %b, required 1", busy); end
    while (n_done == 0 && k < 50) begin
      if (out_valid && fv < 0) fv = k;
      if (mem_rd_en) begin if (frd < 0) frd = k; lrd = k; end
      if (out_valid && out_ready) begin if (fx < 0) fx = k; lx = k; end
      tick(); k++;
    end
    checks += 6;
    if (n_done != 1) begin errors++; $display("FAIL stream_done: got %0d pulses, required 1", n_done); end
    if (fv != 2)     begin errors++; $display("FAIL stream_latency: got %0d, required 2", fv); end
    if (frd != 0 || lrd != 7) begin errors++; $display("FAIL stream_reads: got %0d..%0d, required 0..7", frd, lrd); end
    if (fx != 2 || lx != 9)   begin errors++; $display("FAIL stream_xfers: got %0d..%0d, required 2..9", fx, lx); end
    if (n_rd != TOTAL || n_xfer != TOTAL) begin
      errors++; $display("FAIL stream_count: got rd=%0d xfer=%0d, required %0d", n_rd, n_xfer, TOTAL);
    end
    repeat (3) tick();
    if (n_done != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL stream_after: got done=%0d busy=%b, required 1/0", n_done, busy);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    out_ready = 1'b0;
    start_frame(16'h0010);
    repeat (10) tick();
    checks += 3;
    if (n_rd != DEPTH)      begin errors++; $display("FAIL bp_reads: got %0d, required %0d", n_rd, DEPTH); end
    if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got %b, required 0", mem_rd_en); end
    if (out_valid !== 1'b1 || out_data !== 16'h0010) begin
      errors++; $display("FAIL bp_head: got v=%b d=%h, required v=1 d=0010", out_valid, out_data);
    end
    out_ready = 1'b1;
    while (n_done == 0 && k < 50) begin tick(); k++; end
    checks += 2;
    if (n_done != 1) begin errors++; $display("FAIL bp_done: got %0d pulses, required 1", n_done); end
    if (n_xfer != TOTAL || exp_pix.size() != 0) begin
      errors++; $display("FAIL bp_count: got xfer=%0d left=%0d, required %0d/0", n_xfer, exp_pix.size(), TOTAL);
    end
  endtask

  task automatic test_toggle();
    int k = 0;
    out_ready = 1'b1;
    start_frame(16'h0010);
    while (n_done == 0 && k < 60) begin
      out_ready = (k % 2 == 0);
      if (done) begin
        checks++;
        if (n_xfer != TOTAL) begin errors++; $display("FAIL toggle_done_at: got %0d xfers, required %0d", n_xfer, TOTAL); end
      end
      tick(); k++;
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL toggle_done: got %0d pulses, required 1", n_done); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    int k = 0;
    out_ready = 1'b1;
    start_frame(16'hFFFE);
    while (n_done == 0 && k < 50) begin tick(); k++; end
    checks++;
    if (n_done != 1 || n_rd != TOTAL || exp_addr.size() != 0) begin
      errors++; $display("FAIL wrap_frame: got done=%0d rd=%0d, required 1/%0d", n_done, n_rd, TOTAL);
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    int k = 0, stale = 0;
    out_ready = 1'b1;
    start_frame(16'h0010);
    while (n_xfer < 3 && k < 30) begin tick(); k++; end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if ({busy, done, mem_rd_en, out_valid} !== 4'b0000) begin
      errors++; $display("FAIL mid_rst_ctrl: got %b, required 0000", {busy, done, mem_rd_en, out_valid});
    end
    if (out_data !== '0 || mem_rd_addr !== '0) begin
      errors++; $display("FAIL mid_rst_bus: got d=%h a=%h, required 0/0", out_data, mem_rd_addr);
    end
    exp_pix.delete(); exp_addr.delete();
`ifdef LOADER_LAST_EN
    exp_last.delete();
`endif
    prev_stall = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      if (out_valid || mem_rd_en || busy) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d active cycles, required 0", stale); end
    start_frame(16'h0100);
    repeat (2) tick();
    base_addr = 16'h0300; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (n_done == 0 && k < 50) begin tick(); k++; end
    checks++;
    if (n_done != 1 || n_xfer != TOTAL || exp_pix.size() != 0) begin
      errors++; $display("FAIL mid_refetch: got done=%0d xfer=%0d, required 1/%0d", n_done, n_xfer, TOTAL);
    end
    repeat (2) tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_wrap();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
